// File: rtl/dac_ramp_shaper_if.sv
// Sample-path bundle between the signal composer, the ramp shaper and the DAC.
// The master side feeds samples and control; the slave side is the shaper.
interface dac_ramp_shaper_if #(
    parameter int DATA_W = 16,
    parameter int DAC_W  = 14
);
    logic signed [DATA_W-1:0] signal_in;
    logic                     signal_valid;
    logic                     enable;
    logic [15:0]              ramp_step;
    logic                     clip_clear;
    logic signed [DAC_W-1:0]  dac_out;
    logic                     dac_valid;
    logic [1:0]               state;
    logic                     ramping;
    logic                     clip_sticky;

    modport master (
        output signal_in, signal_valid, enable, ramp_step, clip_clear,
        input  dac_out, dac_valid, state, ramping, clip_sticky
    );

    modport slave (
        input  signal_in, signal_valid, enable, ramp_step, clip_clear,
        output dac_out, dac_valid, state, ramping, clip_sticky
    );
endinterface

// File: rtl/dac_ramp_shaper.sv
// Linear ramp-up/ramp-down envelope on DAC enable/disable, followed by a
// Q1.15 gain, floor scaling and saturation to the DAC word width.
module dac_ramp_shaper #(
    parameter int DATA_W  = 16,
    parameter int ENV_ONE = 32768,
    parameter int DAC_W   = 14
) (
    input  logic             clk,
    input  logic             rst,
    dac_ramp_shaper_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        ACTIVE    = 2'd2,
        RAMP_DOWN = 2'd3
    } st_t;

    localparam int FRAC_W = 15;
    localparam int PROD_W = DATA_W + 17;
    localparam logic [15:0] ENV_MAX    = 16'(ENV_ONE);
    localparam logic [16:0] ENV_MAX_17 = 17'(ENV_ONE);
    localparam logic signed [PROD_W-1:0] SAT_HI = PROD_W'((2 ** (DAC_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] SAT_LO = PROD_W'(-(2 ** (DAC_W - 1)));

    st_t         st, st_nxt;
    logic [15:0] env, env_nxt;
    logic [16:0] env_sum;

    logic                     vld_p1, vld_p2, vld_p3;
    logic signed [DATA_W-1:0] sig_p1;
    logic [15:0]              env_p1;
    logic signed [PROD_W-1:0] prod_p2;
    logic signed [DAC_W-1:0]  dac_p3;
    logic                     clip_sticky_q;
    logic signed [PROD_W-1:0] sig_ext, env_ext, scaled;

    function automatic logic signed [PROD_W-1:0] scale_q15(input logic signed [PROD_W-1:0] v);
        return v >>> FRAC_W;
    endfunction

    function automatic logic signed [DAC_W-1:0] sat_dac(input logic signed [PROD_W-1:0] v);
        if (v > SAT_HI)
            return SAT_HI[DAC_W-1:0];
        else if (v < SAT_LO)
            return SAT_LO[DAC_W-1:0];
        else
            return v[DAC_W-1:0];
    endfunction

    function automatic logic is_clip(input logic signed [PROD_W-1:0] v);
        return (v > SAT_HI) || (v < SAT_LO);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st  <= IDLE;
            env <= '0;
        end else begin
            st  <= st_nxt;
            env <= env_nxt;
        end
    end

    // enable picks the direction first; a coincident sample steps env that way.
    always_comb begin
        st_nxt  = st;
        env_nxt = env;
        env_sum = {1'b0, env} + {1'b0, bus.ramp_step};
        if (!(st == IDLE && !bus.enable)) begin
            if (bus.signal_valid) begin
                if (bus.enable) begin
                    env_nxt = (bus.ramp_step == '0 || env_sum >= ENV_MAX_17) ? ENV_MAX : env_sum[15:0];
                    st_nxt  = (env_nxt == ENV_MAX) ? ACTIVE : RAMP_UP;
                end else begin
                    env_nxt = (bus.ramp_step == '0 || bus.ramp_step >= env) ? '0 : env - bus.ramp_step;
                    st_nxt  = (env_nxt == '0) ? IDLE : RAMP_DOWN;
                end
            end else if (bus.enable) begin
                st_nxt = (st == ACTIVE) ? ACTIVE : RAMP_UP;
            end else begin
                st_nxt = RAMP_DOWN;
            end
        end
    end

    assign sig_ext = PROD_W'(sig_p1);
    assign env_ext = PROD_W'(env_p1);
    assign scaled  = scale_q15(prod_p2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1        <= 1'b0;
            sig_p1        <= '0;
            env_p1        <= '0;
            vld_p2        <= 1'b0;
            prod_p2       <= '0;
            vld_p3        <= 1'b0;
            dac_p3        <= '0;
            clip_sticky_q <= 1'b0;
        end else begin
            // S1: capture the sample with the envelope it was accepted under
            vld_p1 <= bus.signal_valid;
            sig_p1 <= bus.signal_in;
            env_p1 <= env;
            // S2: signed sample times unsigned envelope, full-width product
            vld_p2  <= vld_p1;
            prod_p2 <= sig_ext * env_ext;
            // S3: floor to integer gain, saturate, hold between valid samples
            vld_p3 <= vld_p2;
            if (vld_p2)
                dac_p3 <= sat_dac(scaled);
            if (vld_p2 && is_clip(scaled))
                clip_sticky_q <= 1'b1;
            else if (bus.clip_clear)
                clip_sticky_q <= 1'b0;
        end
    end

    assign bus.dac_out     = dac_p3;
    assign bus.dac_valid   = vld_p3;
    assign bus.state       = st;
    assign bus.ramping     = (st == RAMP_UP) || (st == RAMP_DOWN);
    assign bus.clip_sticky = clip_sticky_q;
endmodule

// File: tb/tb_dac_ramp_shaper.sv
// Directed bench for dac_ramp_shaper: stimulus queues hand-computed outputs,
// a negedge monitor pops and compares them against every dac_valid beat.
module tb_dac_ramp_shaper;
    typedef struct {
        int val;
        int cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;
    exp_t q[$];
    exp_t mon_e;

    dac_ramp_shaper_if #(.DATA_W(16), .DAC_W(14)) bus ();

    dac_ramp_shaper #(.DATA_W(16), .ENV_ONE(32768), .DAC_W(14)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int x, input int e);
        exp_t it;
        bus.signal_in    = 16'(x);
        bus.signal_valid = 1'b1;
        it.val = e;
        it.cyc = cyc + 3;
        q.push_back(it);
        tick(1);
        bus.signal_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.dac_valid) begin
            if (q.size() == 0) begin
                check("unexpected_dac_valid_queue_size", 64'(q.size()), 64'(1));
            end else begin
                mon_e = q.pop_front();
                check("dac_out", 64'(bus.dac_out), 64'(mon_e.val));
                check("latency", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst              = 1'b1;
        bus.signal_in    = '0;
        bus.signal_valid = 1'b0;
        bus.enable       = 1'b0;
        bus.ramp_step    = '0;
        bus.clip_clear   = 1'b0;
        tick(2);
        check("rst_state", 64'(bus.state), 64'(0));
        check("rst_dac_out", 64'(bus.dac_out), 64'(0));
        check("rst_dac_valid", 64'(bus.dac_valid), 64'(0));
        check("rst_clip", 64'(bus.clip_sticky), 64'(0));
        rst = 1'b0;
        tick(2);
        check("idle_after_rst", 64'(bus.state), 64'(0));

        // Ramp up in quarter steps, one sample per cycle
        bus.ramp_step = 16'd8192;
        bus.enable    = 1'b1;
        tick(1);
        check("ramp_up_state", 64'(bus.state), 64'(1));
        check("ramp_up_ramping", 64'(bus.ramping), 64'(1));
        send(8000, 0);
        send(8000, 2000);
        send(8000, 4000);
        check("still_ramp_up", 64'(bus.state), 64'(1));
        send(8000, 6000);
        check("active_after_4", 64'(bus.state), 64'(2));
        check("active_not_ramping", 64'(bus.ramping), 64'(0));
        send(8000, 8000);

        // Clipping at unity gain
        send(20000, 8191);
        send(-20000, -8192);
        tick(4);
        check("clip_set", 64'(bus.clip_sticky), 64'(1));
        bus.clip_clear = 1'b1;
        tick(1);
        bus.clip_clear = 1'b0;
        check("clip_cleared", 64'(bus.clip_sticky), 64'(0));
        send(100, 100);
        tick(4);
        check("clip_stays_clear", 64'(bus.clip_sticky), 64'(0));

        // Reset in the middle of an ACTIVE stream
        for (int i = 0; i < 5; i++) send(5000, 5000);
        check("pre_rst_dac_out", 64'(bus.dac_out), 64'(5000));
        bus.enable = 1'b0;
        rst = 1'b1;
        #1;
        check("async_rst_dac_out", 64'(bus.dac_out), 64'(0));
        check("async_rst_dac_valid", 64'(bus.dac_valid), 64'(0));
        check("async_rst_state", 64'(bus.state), 64'(0));
        q.delete();
        tick(2);
        rst = 1'b0;
        tick(3);
        check("idle_until_enable", 64'(bus.state), 64'(0));

        // Reversal at env=16384; the drop coincides with a sample
        bus.enable = 1'b1;
        tick(1);
        send(8000, 0);
        send(8000, 2000);
        bus.enable = 1'b0;
        send(8000, 4000);
        check("reversal_ramp_down", 64'(bus.state), 64'(3));
        send(8000, 2000);
        check("reversal_idle", 64'(bus.state), 64'(0));
        send(8000, 0);
        send(8000, 0);

        // Bypass: zero step jumps straight to unity
        bus.ramp_step = '0;
        bus.enable    = 1'b1;
        tick(1);
        check("bypass_ramp_up", 64'(bus.state), 64'(1));
        send(-3000, 0);
        check("bypass_active", 64'(bus.state), 64'(2));
        send(-3000, -3000);
        bus.enable = 1'b0;
        send(0, 0);
        check("bypass_down_idle", 64'(bus.state), 64'(0));

        // Half steps with a sample only every other cycle
        bus.ramp_step = 16'd16384;
        bus.enable    = 1'b1;
        tick(1);
        send(4000, 0);
        tick(1);
        check("gap_ramp_up", 64'(bus.state), 64'(1));
        send(4000, 2000);
        tick(1);
        check("gap_active", 64'(bus.state), 64'(2));
        send(4000, 4000);
        bus.ramp_step = '0;
        bus.enable    = 1'b0;
        send(0, 0);

        // Floor rounding at the smallest nonzero envelopes
        bus.ramp_step = 16'd1;
        bus.enable    = 1'b1;
        tick(1);
        send(0, 0);
        send(-1, -1);
        send(1, 0);
        bus.ramp_step = '0;
        bus.enable    = 1'b0;
        send(0, 0);
        check("final_idle", 64'(bus.state), 64'(0));

        tick(6);
        check("scoreboard_drained", 64'(q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
